// File: rtl/acc_seq_4bit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// acc_seq_4bit_pkg : shared {m,s} control words and sequencer state encodings
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
package acc_seq_4bit_pkg;

  localparam logic [4:0] c_hold_ctrl = 5'b11111;  // logic mode, F = A
  localparam logic [4:0] c_clr_ctrl  = 5'b10011;  // logic mode, F = 0
  localparam logic [4:0] c_add_ctrl  = 5'b01001;  // arithmetic, F = A plus B

`ifdef ACC_SEQ_CLR_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } state_e;
`endif

endpackage
`default_nettype wire

// File: rtl/acc_4bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// acc_4bit : 4-bit ALU accumulator; A <= F each edge, clears to 0 on carry-out
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module acc_4bit
  import acc_seq_4bit_pkg::*;
(
  input  logic       clk,
  input  logic [4:0] ctrl,
  input  logic [3:0] b,
  output logic [3:0] aa,
  output logic       cout
);

  logic [3:0] a_q;
  logic [3:0] a_d;
  logic [4:0] sum;

  always_comb begin
    sum  = {1'b0, a_q};
    aa   = a_q;
    if (ctrl[4]) begin
      case (ctrl[3:0])
        4'b0000: aa = ~a_q;
        4'b0011: aa = 4'h0;
        4'b0110: aa = a_q ^ b;
        4'b1010: aa = b;
        4'b1011: aa = a_q & b;
        4'b1100: aa = 4'hF;
        4'b1110: aa = a_q | b;
        default: aa = a_q;
      endcase
    end else begin
      if (ctrl == c_add_ctrl) sum = {1'b0, a_q} + {1'b0, b};
      aa = sum[3:0];
    end
    cout = ~ctrl[4] & sum[4];
    a_d  = cout ? 4'h0 : aa;
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
  end

endmodule
`default_nettype wire

// File: rtl/acc_seq_4bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// acc_seq_4bit : command-driven burst initiator for acc_4bit with registered
//                valid/ready response. Optional clear cycle: ACC_SEQ_CLR_EN.
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module acc_seq_4bit
  import acc_seq_4bit_pkg::*;
#(
  parameter int unsigned CNT_W     = 4,
  parameter logic [4:0]  HOLD_CTRL = c_hold_ctrl,
  parameter logic [4:0]  CLR_CTRL  = c_clr_ctrl
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [3:0]       cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
`ifdef ACC_SEQ_CLR_EN
  input  logic             cmd_clr,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic             rsp_ovf,
  output logic             busy,
  output logic [4:0]       acc_ctrl,
  output logic [3:0]       acc_b,
  input  logic [3:0]       acc_aa,
  input  logic             acc_cout
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [3:0]       b_q, b_d;
  logic             ovf_q, ovf_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [3:0]       rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic [4:0]       acc_ctrl_q, acc_ctrl_d;
  logic [3:0]       acc_b_q, acc_b_d;

`ifndef ACC_SEQ_CLR_EN
  logic unused_clr_ctrl;
  assign unused_clr_ctrl = ^CLR_CTRL;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    b_d         = b_q;
    ovf_d       = ovf_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    acc_ctrl_d  = HOLD_CTRL;
    acc_b_d     = 4'h0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d  = cmd_op;
          b_d   = cmd_b;
          cnt_d = cmd_cnt;
          ovf_d = 1'b0;
          state_d = (cmd_cnt == '0) ? ST_SAMPLE : ST_RUN;
`ifdef ACC_SEQ_CLR_EN
          if (cmd_clr) state_d = ST_CLEAR;
`endif
        end
      end
`ifdef ACC_SEQ_CLR_EN
      ST_CLEAR: state_d = (cnt_q == '0) ? ST_SAMPLE : ST_RUN;
`endif
      ST_RUN: begin
        // carry only means something on edges where our op is applied
        if (acc_cout) ovf_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        rsp_data_d  = acc_aa;
        rsp_ovf_d   = ovf_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // outputs are registered, so decode them from the state being entered
    case (state_d)
      ST_RUN: begin
        acc_ctrl_d = op_d;
        acc_b_d    = b_d;
      end
`ifdef ACC_SEQ_CLR_EN
      ST_CLEAR: acc_ctrl_d = CLR_CTRL;
`endif
      default: ;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= HOLD_CTRL;
      b_q         <= 4'h0;
      ovf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'h0;
      rsp_ovf_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      acc_ctrl_q  <= HOLD_CTRL;
      acc_b_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      b_q         <= b_d;
      ovf_q       <= ovf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      acc_ctrl_q  <= acc_ctrl_d;
      acc_b_q     <= acc_b_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = busy_q;
  assign acc_ctrl  = acc_ctrl_q;
  assign acc_b     = acc_b_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_seq_4bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_acc_seq_4bit : acc_seq_4bit driving acc_4bit, scoreboard-checked responses
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_acc_seq_4bit;

  localparam logic [4:0] HOLD = 5'b11111;
  localparam logic [4:0] CLR  = 5'b10011;
  localparam logic [4:0] ADD  = 5'b01001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_op = HOLD;
  logic [3:0] cmd_b = 4'h0;
  logic [3:0] cmd_cnt = 4'h0;
`ifdef ACC_SEQ_CLR_EN
  logic       cmd_clr = 1'b0;
`endif
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       rsp_ovf;
  logic       busy;
  logic [4:0] acc_ctrl;
  logic [3:0] acc_b;
  logic [3:0] acc_aa;
  logic       acc_cout;

  always #5 clk = ~clk;

  acc_seq_4bit u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_b     (cmd_b),
    .cmd_cnt   (cmd_cnt),
`ifdef ACC_SEQ_CLR_EN
    .cmd_clr   (cmd_clr),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy),
    .acc_ctrl  (acc_ctrl),
    .acc_b     (acc_b),
    .acc_aa    (acc_aa),
    .acc_cout  (acc_cout)
  );

  acc_4bit u_acc (
    .clk  (clk),
    .ctrl (acc_ctrl),
    .b    (acc_b),
    .aa   (acc_aa),
    .cout (acc_cout)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] data;
    logic       ovf;
    int         lat;
  } exp_t;
  exp_t sb[$];

  logic [3:0] m_acc = 4'h0;
  logic       m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // accumulator reference: add clears to zero on carry-out
  task automatic m_step(input logic [4:0] op, input logic [3:0] b);
    logic [4:0] s;
    if (op == ADD) begin
      s = {1'b0, m_acc} + {1'b0, b};
      if (s[4]) begin
        m_acc = 4'h0;
        m_ovf = 1'b1;
      end else begin
        m_acc = s[3:0];
      end
    end else if (op == CLR) begin
      m_acc = 4'h0;
    end
  endtask

  task automatic do_cmd(input logic [4:0] op, input logic [3:0] b, input logic [3:0] cnt,
                        input logic clr, input int stall);
    exp_t e;
    int   lat, n_op, hold_bad, stall_bad, guard;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("cmd_ready_idle", {31'd0, cmd_ready}, 1);

    m_ovf = 1'b0;
    if (clr) m_acc = 4'h0;
    for (int i = 0; i < int'(cnt); i++) m_step(op, b);
    e.data = m_acc;
    e.ovf  = m_ovf;
    e.lat  = int'(cnt) + 2 + (clr ? 1 : 0);
    sb.push_back(e);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_b     = b;
    cmd_cnt   = cnt;
`ifdef ACC_SEQ_CLR_EN
    cmd_clr   = clr;
`endif
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1; n_op = 0; hold_bad = 0;
    while (!rsp_valid && lat < 40) begin
      if (acc_ctrl == op && acc_b == b) n_op++;
      if (acc_ctrl != HOLD) hold_bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 0, 1);
      void'(sb.pop_front());
      return;
    end

    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("rsp_data", {28'd0, rsp_data}, {28'd0, e.data});
    check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
    check("busy_resp", {31'd0, busy}, 1);
    if (op != HOLD) check("run_len", n_op, int'(cnt));
    if (cnt == 4'd0 && !clr) check("hold_ctrl", hold_bad, 0);

    // stray commands while the response waits must be ignored
    stall_bad = 0;
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1; cmd_op = ADD; cmd_b = 4'hF; cmd_cnt = 4'd3;
      if (!(rsp_valid && rsp_data == e.data && rsp_ovf == e.ovf && !cmd_ready &&
            acc_aa == e.data && acc_ctrl == HOLD)) stall_bad++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (stall > 0) check("stall_hold", stall_bad, 0);

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_done", {29'd0, rsp_valid, busy, cmd_ready}, 32'd1);
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] b, input logic [3:0] cnt,
                       input logic clr, input int stall);
`ifdef ACC_SEQ_CLR_EN
    do_cmd(op, b, cnt, clr, stall);
`else
    if (clr) do_cmd(CLR, 4'h0, 4'd1, 1'b0, 0);
    do_cmd(op, b, cnt, 1'b0, stall);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcount;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_data", {28'd0, rsp_data}, 0);
    check("rst_rsp_ovf", {31'd0, rsp_ovf}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_acc_ctrl", {27'd0, acc_ctrl}, {27'd0, HOLD});
    check("rst_acc_b", {28'd0, acc_b}, 0);

    issue(ADD, 4'd3, 4'd4, 1'b1, 5);   // 12, held through a 5-cycle stall
    issue(ADD, 4'd7, 4'd0, 1'b0, 0);   // read only: 12
    issue(ADD, 4'd1, 4'd2, 1'b0, 0);   // 14
    issue(ADD, 4'd5, 4'd4, 1'b1, 0);   // 5,10,15, carry -> 0

    // reset during the second RUN cycle of a 6-edge burst
    cmd_valid = 1'b1; cmd_op = ADD; cmd_b = 4'd1; cmd_cnt = 4'd6;
`ifdef ACC_SEQ_CLR_EN
    cmd_clr = 1'b0;
`endif
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_step(ADD, 4'd1);
    m_step(ADD, 4'd1);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_acc_ctrl", {27'd0, acc_ctrl}, {27'd0, HOLD});
    check("mid_rst_acc_b", {28'd0, acc_b}, 0);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) vcount++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_rsp", vcount, 0);

    issue(HOLD, 4'd9, 4'd0, 1'b0, 0);  // accumulator kept the two issued adds
    do_cmd(CLR, 4'h0, 4'd1, 1'b0, 0);  // clear via op
    issue(ADD, 4'd1, 4'd15, 1'b0, 0);  // longest burst: 15
    issue(ADD, 4'd1, 4'd1, 1'b0, 2);   // wraps -> 0 with ovf

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
